alu_cmd_sequencer: RTL

Upstream command stage for the registered 8-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues one command at a time to the registered ALU (operands, opcode, enable pulse), captures the registered result and zero flag, and presents them in order on a valid/ready response port.

---
 rtl/alu_cmd_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a small FIFO, issues them one at a
// time to a registered ALU, and returns the captured results in order.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [7:0]               cmd_a_i,
  input  logic [7:0]               cmd_b_i,
  input  logic [2:0]               cmd_op_i,
  output logic                     alu_en_o,
  output logic [7:0]               alu_a_o,
  output logic [7:0]               alu_b_o,
  output logic [2:0]               alu_op_o,
  input  logic [7:0]               alu_result_i,
  input  logic                     alu_zero_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [7:0]               rsp_result_o,
  output logic                     rsp_zero_o,
  output logic [2:0]               rsp_op_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  // FIFO entry layout: {a, b, op}
  logic [18:0]   mem [DEPTH];
  logic [18:0]   head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;

  logic          alu_en_q, alu_en_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_result_q, rsp_result_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic [2:0]    rsp_op_q, rsp_op_d;

  logic          push;
  logic          pop;

  // Ready comes straight from the registered count; a pop in the same cycle
  // does not free a slot for a push into a full FIFO.
  assign cmd_ready_o = rst_i && (count_q != CW'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head        = mem[rd_ptr_q];

  // Next-state logic: FSM sequencing, pop decision, pointer and count update.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    alu_en_d     = alu_en_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_op_d     = rsp_op_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      ISSUE: begin
        alu_en_d = 1'b0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        rsp_result_d = alu_result_i;
        rsp_zero_d   = alu_zero_i;
        rsp_op_d     = alu_op_q;
        rsp_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop loads the head command into the ALU operand registers and
    // fires the single-cycle enable.
    if (pop) begin
      {alu_a_d, alu_b_d, alu_op_d} = head;
      alu_en_d = 1'b1;
      state_d  = ISSUE;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= {cmd_a_i, cmd_b_i, cmd_op_i};
  end

  // State registers; reset drops all buffered and in-flight work.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_en_q     <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_en_q     <= alu_en_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_op_q     <= rsp_op_d;
    end
  end

  assign alu_en_o     = alu_en_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_op_o     = rsp_op_q;
  assign count_o      = count_q;

endmodule
